// File: rtl/mem_arb_if.sv
// Requester-side access port of mem_arb: request/command from a master,
// grant, completion pulse and read data back from the arbiter.
interface mem_arb_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          done;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port arbiter/sequencer for a single-port synchronous-read data memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_arb #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arb_if.slave      m0,
    mem_arb_if.slave      m1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state;
    logic   last;
    logic   cmd_id;
    logic   cmd_we;
    logic   tie0;
    logic   pick0;
    logic   pick1;

`ifdef MEM_ARB_RR_EN
    // Port 0 wins a tie only when port 1 was the last one served.
    assign tie0 = last;
`else
    // last is still tracked, but fixed priority makes it irrelevant here.
    assign tie0 = last | 1'b1;
`endif

    assign pick0 = m0.req & (~m1.req | tie0);
    assign pick1 = m1.req & ~pick0;

    assign m0.gnt = (state == IDLE) & pick0;
    assign m1.gnt = (state == IDLE) & pick1;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cmd_id    <= 1'b0;
            cmd_we    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0.done   <= 1'b0;
            m1.done   <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
        end else begin
            // mem_* are only non-zero for the single ISSUE cycle.
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0.done   <= 1'b0;
            m1.done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick0 || pick1) begin
                        cmd_id    <= pick1;
                        cmd_we    <= pick1 ? m1.we : m0.we;
                        last      <= pick1;
                        mem_en    <= 1'b1;
                        mem_we    <= pick1 ? m1.we : m0.we;
                        mem_addr  <= pick1 ? m1.addr : m0.addr;
                        mem_wdata <= pick1 ? m1.wdata : m0.wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_we) begin
                        if (cmd_id) m1.done <= 1'b1;
                        else        m0.done <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cmd_id) begin
                        m1.rdata <= mem_rdata;
                        m1.done  <= 1'b1;
                    end else begin
                        m0.rdata <= mem_rdata;
                        m0.done  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small synchronous-read memory model;
// tie-break expectations follow MEM_ARB_RR_EN.
module tb_mem_arb;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] mem [0:255];
    int            errors = 0;
    int            checks = 0;

    mem_arb_if #(.AW(AW), .DW(DW)) p0 ();
    mem_arb_if #(.AW(AW), .DW(DW)) p1 ();

    mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .m0(p0), .m1(p1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: preloaded word at 0x05, one-cycle read latency.
    always @(posedge clk) begin
        if (rst) mem[5] <= 32'h12345678;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        p0.req = 0; p0.we = 0; p0.addr = 0; p0.wdata = 0;
        p1.req = 0; p1.we = 0; p1.addr = 0; p1.wdata = 0;
        rst = 1;
        tick; tick;
        rst = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%0h/%0h exp=0/0", mem_en, mem_we); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got=%0h/%0h exp=0/0", mem_addr, mem_wdata); end
        checks++; if (p0.done !== 1'b0 || p1.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h/%0h exp=0/0", p0.done, p1.done); end
        checks++; if (p0.rdata !== 32'h0 || p1.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%0h/%0h exp=0/0", p0.rdata, p1.rdata); end
        checks++; if (p0.gnt !== 1'b0 || p1.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%0h/%0h exp=0/0", p0.gnt, p1.gnt); end
    endtask

    task automatic test_write_read;
        p0.we = 1; p0.addr = 8'h10; p0.wdata = 32'hDEADBEEF; p0.req = 1;
        #1;
        checks++; if (p0.gnt !== 1'b1 || p1.gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got=%0h/%0h exp=1/0", p0.gnt, p1.gnt); end
        tick; p0.req = 0;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_en got=%0h/%0h exp=1/1", mem_en, mem_we); end
        checks++; if (mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_bus got=%0h/%0h exp=10/deadbeef", mem_addr, mem_wdata); end
        tick;
        checks++; if (p0.done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wr_done got=%0h busy=%0h exp=1 busy=0", p0.done, busy); end
        p0.we = 0; p0.req = 1;
        #1;
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%0h exp=1", p0.gnt); end
        tick; p0.req = 0;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_en got=%0h/%0h exp=1/0", mem_en, mem_we); end
        tick;
        checks++; if (p0.done !== 1'b0 || busy !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL rd_wait got done=%0h busy=%0h en=%0h exp=0/1/0", p0.done, busy, mem_en); end
        tick;
        checks++; if (p0.done !== 1'b1 || p0.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_done got=%0h data=%0h exp=1 deadbeef", p0.done, p0.rdata); end
        tick;
        checks++; if (p0.done !== 1'b0 || p0.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got=%0h data=%0h exp=0 deadbeef", p0.done, p0.rdata); end
    endtask

    task automatic test_m1_read;
        p1.we = 0; p1.addr = 8'h05; p1.req = 1;
        #1;
        checks++; if (p1.gnt !== 1'b1 || p0.gnt !== 1'b0) begin errors++; $display("FAIL m1_gnt got=%0h/%0h exp=1/0", p1.gnt, p0.gnt); end
        tick; p1.req = 0;
        checks++; if (mem_addr !== 8'h05) begin errors++; $display("FAIL m1_addr got=%0h exp=05", mem_addr); end
        tick;
        checks++; if (p1.done !== 1'b0) begin errors++; $display("FAIL m1_early_done got=%0h exp=0", p1.done); end
        tick;
        checks++; if (p1.done !== 1'b1 || p1.rdata !== 32'h12345678) begin errors++; $display("FAIL m1_done got=%0h data=%0h exp=1 12345678", p1.done, p1.rdata); end
        checks++; if (p0.rdata !== 32'hDEADBEEF || p0.done !== 1'b0) begin errors++; $display("FAIL m1_m0_untouched got=%0h done=%0h exp=deadbeef 0", p0.rdata, p0.done); end
    endtask

    task automatic test_tie;
        logic got;
        int   exp_id;
        int   n1;
        int   exp_n1;
        n1 = 0;
        p0.we = 1; p0.addr = 8'h20; p0.wdata = 32'hA0A0A0A0;
        p1.we = 1; p1.addr = 8'h30; p1.wdata = 32'hB1B1B1B1;
        p0.req = 1; p1.req = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            got = 0;
            for (int c = 0; c < 4; c++) begin
                if (p0.gnt || p1.gnt) begin
                    got = 1;
                    break;
                end
                tick;
            end
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL tie_timeout txn=%0d got=no gnt exp=gnt", i); end
            checks++; if (p0.gnt && p1.gnt) begin errors++; $display("FAIL tie_both txn=%0d got=1/1 exp=one", i); end
            checks++; if (int'(p1.gnt) !== exp_id) begin errors++; $display("FAIL tie_order txn=%0d got=m%0d exp=m%0d", i, p1.gnt, exp_id); end
            n1 += int'(p1.gnt);
            tick;
            if (i == 3) begin p0.req = 0; p1.req = 0; end
            checks++; if (mem_addr !== (exp_id == 1 ? 8'h30 : 8'h20)) begin errors++; $display("FAIL tie_addr txn=%0d got=%0h exp=%0h", i, mem_addr, (exp_id == 1 ? 8'h30 : 8'h20)); end
        end
        tick;
`ifdef MEM_ARB_RR_EN
        exp_n1 = 2;
`else
        exp_n1 = 0;
`endif
        checks++; if (n1 !== exp_n1) begin errors++; $display("FAIL tie_m1_count got=%0d exp=%0d", n1, exp_n1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_end_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        p0.we = 0; p0.addr = 8'h10; p0.req = 1;
        #1;
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt got=%0h exp=1", p0.gnt); end
        tick; p0.req = 0;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_wait_busy got=%0h exp=1", busy); end
        rst = 1;
        #1;
        checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rm_abort got busy=%0h en=%0h exp=0/0", busy, mem_en); end
        checks++; if (p0.rdata !== 32'h0 || p0.done !== 1'b0) begin errors++; $display("FAIL rm_rdata got=%0h done=%0h exp=0/0", p0.rdata, p0.done); end
        tick;
        rst = 0;
        tick;
        checks++; if (p0.done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_no_done got=%0h busy=%0h exp=0/0", p0.done, busy); end
        p0.req = 1;
        #1;
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL rm_regnt got=%0h exp=1", p0.gnt); end
        tick; p0.req = 0;
        tick; tick;
        checks++; if (p0.done !== 1'b1 || p0.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rm_reread got=%0h data=%0h exp=1 deadbeef", p0.done, p0.rdata); end
    endtask

    task automatic test_drop_req;
        logic bad;
        p0.we = 1; p0.addr = 8'h40; p0.wdata = 32'h00000001; p0.req = 1;
        #1;
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL dr_gnt got=%0h exp=1", p0.gnt); end
        tick;
        p0.req = 0;
        p1.we = 1; p1.addr = 8'h77; p1.wdata = 32'h00000002; p1.req = 1;
        #1;
        checks++; if (p1.gnt !== 1'b0) begin errors++; $display("FAIL dr_busy_gnt got=%0h exp=0", p1.gnt); end
        tick;
        p1.req = 0;
        #1;
        checks++; if (p0.done !== 1'b1) begin errors++; $display("FAIL dr_m0_done got=%0h exp=1", p0.done); end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (p1.gnt || busy || (mem_en && mem_addr == 8'h77)) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL dr_m1_served got=%0h exp=0", bad); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_m1_read;
        test_tie;
        test_reset_mid;
        test_drop_req;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
